// File: rtl/hex_stream_pkg.sv
// Shared types and constants for the ASCII hex word streamer.
package hex_stream_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIGITS = 2'd1;
  localparam logic [1:0] ST_CR     = 2'd2;
  localparam logic [1:0] ST_LF     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_DIGITS = ST_DIGITS,
    S_CR     = ST_CR,
    S_LF     = ST_LF
  } state_t;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;

  // Width needed to hold digit indices 0..nchar-1, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned nchar);
    int unsigned w;
    w = 32'd1;
    for (int unsigned i = 32'd1; i < 32'd7; i++) begin
      if (nchar > (32'd1 << i)) begin
        w = i + 32'd1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational nibble-to-ASCII hex digit mapping, case selectable.
module hex_nibble_ascii
  import hex_stream_pkg::*;
#(
  parameter bit LOWERCASE = 1'b0
) (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_char
);

  // Digits 0-9 from '0', letters offset from 'A' or 'a'.
  always_comb begin
    o_char = ASCII_ZERO;
    if (i_nibble < 4'd10) begin
      o_char = ASCII_ZERO + {4'd0, i_nibble};
    end else if (LOWERCASE) begin
      o_char = ASCII_LOWER_A + {4'd0, i_nibble} - 8'd10;
    end else begin
      o_char = ASCII_UPPER_A + {4'd0, i_nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_word_streamer_chk.sv
// Interface properties of hex_word_streamer, observed from its ports only.
module hex_word_streamer_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       i_in_ready,
  input logic       i_out_valid,
  input logic       i_out_ready,
  input logic [7:0] i_out_char,
  input logic       i_busy
);

  // A stalled character must stay offered and unchanged.
  a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (i_out_valid && !i_out_ready) |=> (i_out_valid && $stable(i_out_char)));

  a_busy_vs_ready: assert property (@(posedge clk) disable iff (!rst_n)
    (i_busy == !i_in_ready));

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_in_ready && i_out_valid));

endmodule

// File: rtl/hex_word_streamer.sv
// Serializes a DATA_W-bit word as ASCII hex, MS nibble first, optional CR/LF.
// Build macro HEX_STREAM_LEADZERO_SUPPRESS_EN drops leading zero digits.
module hex_word_streamer
  import hex_stream_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter bit          LOWERCASE   = 1'b0,
  parameter bit          APPEND_CRLF = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              busy
);

  localparam int unsigned      NCHAR    = DATA_W / 32'd4;
  localparam int unsigned      IDX_W    = idx_width(NCHAR);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHAR - 32'd1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);

  state_t            r_state;
  logic [DATA_W-1:0] r_word;
  logic [IDX_W-1:0]  r_idx;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [7:0]        r_out_char;
  logic              r_busy;

  logic              w_accept;
  logic              w_out_hs;
  logic [DATA_W-1:0] w_load_word;
  logic [IDX_W-1:0]  w_load_idx;
  logic [DATA_W-1:0] w_shift_word;
  logic [3:0]        w_conv_nib;
  logic [7:0]        w_conv_char;

  assign w_accept     = in_valid && r_in_ready;
  assign w_out_hs     = r_out_valid && out_ready;
  assign w_shift_word = r_word << 3'd4;

`ifdef HEX_STREAM_LEADZERO_SUPPRESS_EN
  logic [IDX_W-1:0] w_lz_cnt;
  logic             w_lz_seen;

  // Nibble 0 is never inspected, so an all-zero word still keeps one '0'.
  always_comb begin
    w_lz_cnt  = '0;
    w_lz_seen = 1'b0;
    for (int i = int'(NCHAR) - 1; i > 0; i--) begin
      if (!w_lz_seen && (in_data[4*i +: 4] == 4'd0)) begin
        w_lz_cnt = w_lz_cnt + IDX_ONE;
      end else begin
        w_lz_seen = 1'b1;
      end
    end
  end

  assign w_load_word = in_data << {w_lz_cnt, 2'b00};
  assign w_load_idx  = w_lz_cnt;
`else
  assign w_load_word = in_data;
  assign w_load_idx  = '0;
`endif

  // One converter: the incoming word's top nibble on accept, else the next digit.
  always_comb begin
    w_conv_nib = 4'd0;
    if (w_accept) begin
      w_conv_nib = w_load_word[DATA_W-1 -: 4];
    end else begin
      w_conv_nib = w_shift_word[DATA_W-1 -: 4];
    end
  end

  hex_nibble_ascii #(
    .LOWERCASE(LOWERCASE)
  ) u_nibble_ascii (
    .i_nibble(w_conv_nib),
    .o_char  (w_conv_char)
  );

  // Stream FSM; every output is registered so nothing combinational reaches out_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_char  <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_word      <= w_load_word;
            r_idx       <= w_load_idx;
            r_out_char  <= w_conv_char;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_DIGITS;
          end
        end
        S_DIGITS: begin
          if (w_out_hs) begin
            if (r_idx == LAST_IDX) begin
              if (APPEND_CRLF) begin
                r_out_char <= ASCII_CR;
                r_state    <= S_CR;
              end else begin
                r_out_char  <= 8'h00;
                r_out_valid <= 1'b0;
                r_in_ready  <= 1'b1;
                r_busy      <= 1'b0;
                r_state     <= S_IDLE;
              end
            end else begin
              r_word     <= w_shift_word;
              r_idx      <= r_idx + IDX_ONE;
              r_out_char <= w_conv_char;
            end
          end
        end
        S_CR: begin
          if (w_out_hs) begin
            r_out_char <= ASCII_LF;
            r_state    <= S_LF;
          end
        end
        S_LF: begin
          if (w_out_hs) begin
            r_out_char  <= 8'h00;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_char  <= 8'h00;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;
  assign busy      = r_busy;

endmodule

// File: tb/tb_hex_word_streamer.sv
// Randomized self-checking bench for hex_word_streamer against a string-level model.
module tb_hex_word_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv   [3];
  logic        ir   [3];
  logic [31:0] idat [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [7:0]  oc   [3];
  logic        bsy  [3];

  int errors = 0;
  int checks = 0;

  // k=0: 32-bit upper+CRLF, k=1: 32-bit lower no CRLF, k=2: 4-bit upper+CRLF
  hex_word_streamer #(.DATA_W(32), .LOWERCASE(1'b0), .APPEND_CRLF(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_char(oc[0]), .busy(bsy[0]));
  hex_word_streamer #(.DATA_W(32), .LOWERCASE(1'b1), .APPEND_CRLF(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_char(oc[1]), .busy(bsy[1]));
  hex_word_streamer #(.DATA_W(4), .LOWERCASE(1'b0), .APPEND_CRLF(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2][3:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_char(oc[2]), .busy(bsy[2]));

  hex_word_streamer_chk u_chk0 (.clk(clk), .rst_n(rst_n), .i_in_ready(ir[0]), .i_out_valid(ov[0]),
    .i_out_ready(ordy[0]), .i_out_char(oc[0]), .i_busy(bsy[0]));
  hex_word_streamer_chk u_chk1 (.clk(clk), .rst_n(rst_n), .i_in_ready(ir[1]), .i_out_valid(ov[1]),
    .i_out_ready(ordy[1]), .i_out_char(oc[1]), .i_busy(bsy[1]));
  hex_word_streamer_chk u_chk2 (.clk(clk), .rst_n(rst_n), .i_in_ready(ir[2]), .i_out_valid(ov[2]),
    .i_out_ready(ordy[2]), .i_out_char(oc[2]), .i_busy(bsy[2]));

  function automatic int cfg_dw(input int k);
    return (k == 2) ? 4 : 32;
  endfunction

  function automatic bit cfg_lc(input int k);
    return (k == 1);
  endfunction

  function automatic bit cfg_crlf(input int k);
    return (k != 1);
  endfunction

  function automatic string to_hex(input byte unsigned q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  // Expected text: hex digits of the word as a person would write them, then CR LF.
  task automatic model(input int k, input logic [31:0] word, output byte unsigned q[$]);
    int n, first, d;
    n = cfg_dw(k) / 4;
    first = 0;
    q = {};
`ifdef HEX_STREAM_LEADZERO_SUPPRESS_EN
    while (first < n - 1 && ((word >> (4 * (n - 1 - first))) & 32'hF) == 32'h0) first++;
`endif
    for (int i = first; i < n; i++) begin
      d = int'((word >> (4 * (n - 1 - i))) & 32'hF);
      if (d < 10) q.push_back(8'(48 + d));
      else        q.push_back(8'((cfg_lc(k) ? 97 : 65) + d - 10));
    end
    if (cfg_crlf(k)) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
  endtask

  task automatic accept(input int k, input logic [31:0] word, input bit hold);
    int t;
    t = 0;
    @(negedge clk);
    while (ir[k] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    iv[k]   = 1'b1;
    idat[k] = word;
    @(posedge clk);
    #1;
    if (!hold) iv[k] = 1'b0;
  endtask

  // Drives out_ready per mode and records handshaken characters plus protocol slips.
  task automatic collect(input int k, input int mode, input int nstop, input bit scramble,
                         output byte unsigned q[$], output int gap_v, output int stall_v,
                         output int ctl_v);
    bit         stalled;
    logic [7:0] held;
    int         cyc;
    q = {};
    gap_v = 0; stall_v = 0; ctl_v = 0;
    stalled = 1'b0; held = 8'h00; cyc = 0;
    while (q.size() < nstop && cyc < 300) begin
      @(negedge clk);
      case (mode)
        0:       ordy[k] = 1'b1;
        1:       ordy[k] = (cyc % 3 == 0);
        default: ordy[k] = 1'($urandom_range(0, 1));
      endcase
      if (scramble) idat[k] = $urandom;
      if (ov[k] !== 1'b1) gap_v++;
      if (stalled && oc[k] !== held) stall_v++;
      if (bsy[k] !== 1'b1 || ir[k] !== 1'b0) ctl_v++;
      if (ov[k] === 1'b1 && ordy[k]) q.push_back(oc[k]);
      stalled = (ov[k] === 1'b1) && !ordy[k];
      held = oc[k];
      cyc++;
      @(posedge clk);
    end
    #1;
    ordy[k] = 1'b0;
  endtask

  task automatic test_reset();
    #13;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || oc[k] !== 8'h00 || bsy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state k=%0d got ir=%b ov=%b oc=%h busy=%b required 1 0 00 0",
                 k, ir[k], ov[k], oc[k], bsy[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || bsy[k] !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset k=%0d got ir=%b ov=%b busy=%b required 1 0 0",
                 k, ir[k], ov[k], bsy[k]);
      end
    end
  endtask

  task automatic test_deadbeef();
    byte unsigned e[$], q[$];
    int g, s, c;
    model(0, 32'hDEADBEEF, e);
    accept(0, 32'hDEADBEEF, 1'b0);
    collect(0, 0, e.size(), 1'b0, q, g, s, c);
    checks++;
    if (to_hex(q) != to_hex(e)) begin
      errors++;
      $display("FAIL deadbeef_seq got %s required %s", to_hex(q), to_hex(e));
    end
    checks++;
    if (g != 0 || c != 0) begin
      errors++;
      $display("FAIL deadbeef_timing got gaps=%0d ctl=%0d required 0 0", g, c);
    end
    @(negedge clk);
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL deadbeef_idle got ir=%b ov=%b busy=%b required 1 0 0", ir[0], ov[0], bsy[0]);
    end
  endtask

  task automatic test_backpressure();
    byte unsigned e[$], q[$];
    int g, s, c;
    model(0, 32'hDEADBEEF, e);
    accept(0, 32'hDEADBEEF, 1'b0);
    collect(0, 1, e.size(), 1'b0, q, g, s, c);
    checks++;
    if (to_hex(q) != to_hex(e)) begin
      errors++;
      $display("FAIL stall_seq got %s required %s", to_hex(q), to_hex(e));
    end
    checks++;
    if (s != 0 || g != 0 || c != 0) begin
      errors++;
      $display("FAIL stall_hold got changes=%0d gaps=%0d ctl=%0d required 0 0 0", s, g, c);
    end
  endtask

  task automatic test_lowercase();
    byte unsigned e[$], q[$];
    int g, s, c;
    model(1, 32'h00ABCDEF, e);
    accept(1, 32'h00ABCDEF, 1'b0);
    collect(1, 0, e.size(), 1'b0, q, g, s, c);
    checks++;
    if (to_hex(q) != to_hex(e) || g != 0) begin
      errors++;
      $display("FAIL lower_seq got %s gaps=%0d required %s gaps=0", to_hex(q), g, to_hex(e));
    end
    @(negedge clk);
    checks++;
    if (ov[1] !== 1'b0 || ir[1] !== 1'b1) begin
      errors++;
      $display("FAIL lower_no_term got ov=%b ir=%b required 0 1", ov[1], ir[1]);
    end
  endtask

  task automatic test_back_to_back();
    byte unsigned ea[$], eb[$], q[$];
    int g, s, c;
    model(0, 32'h12345678, ea);
    model(0, 32'h9ABCDEF0, eb);
    accept(0, 32'h12345678, 1'b1);
    collect(0, 0, ea.size(), 1'b1, q, g, s, c);
    checks++;
    if (to_hex(q) != to_hex(ea) || g != 0 || c != 0) begin
      errors++;
      $display("FAIL b2b_first got %s gaps=%0d ctl=%0d required %s 0 0", to_hex(q), g, c, to_hex(ea));
    end
    @(negedge clk);
    idat[0] = 32'h9ABCDEF0;
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got ir=%b ov=%b required 1 0", ir[0], ov[0]);
    end
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    collect(0, 0, eb.size(), 1'b0, q, g, s, c);
    checks++;
    if (to_hex(q) != to_hex(eb) || g != 0) begin
      errors++;
      $display("FAIL b2b_second got %s gaps=%0d required %s 0", to_hex(q), g, to_hex(eb));
    end
  endtask

  task automatic test_reset_midstream();
    byte unsigned e[$], q[$];
    int g, s, c;
    accept(0, 32'hCAFEF00D, 1'b0);
    collect(0, 0, 3, 1'b0, q, g, s, c);
    checks++;
    if (to_hex(q) != "43 41 46 ") begin
      errors++;
      $display("FAIL midrst_prefix got %s required 43 41 46", to_hex(q));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || bsy[0] !== 1'b0 || ir[0] !== 1'b1 || oc[0] !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async got ov=%b busy=%b ir=%b oc=%h required 0 0 1 00",
               ov[0], bsy[0], ir[0], oc[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model(0, 32'h13579BDF, e);
    accept(0, 32'h13579BDF, 1'b0);
    collect(0, 0, e.size(), 1'b0, q, g, s, c);
    checks++;
    if (to_hex(q) != to_hex(e) || g != 0) begin
      errors++;
      $display("FAIL midrst_next got %s gaps=%0d required %s 0", to_hex(q), g, to_hex(e));
    end
  endtask

  task automatic test_leadzero_edges();
    logic [31:0] words [5];
    int          ks    [5];
    byte unsigned e[$], q[$];
    int g, s, c;
    words = '{32'h00000A5F, 32'h00000000, 32'h80000000, 32'h00000000, 32'h0000000B};
    ks    = '{0, 0, 0, 2, 2};
    for (int i = 0; i < 5; i++) begin
      model(ks[i], words[i], e);
      accept(ks[i], words[i], 1'b0);
      collect(ks[i], 0, e.size(), 1'b0, q, g, s, c);
      checks++;
      if (to_hex(q) != to_hex(e) || g != 0) begin
        errors++;
        $display("FAIL edge_word k=%0d w=%h got %s gaps=%0d required %s 0",
                 ks[i], words[i], to_hex(q), g, to_hex(e));
      end
    end
  endtask

  task automatic test_random();
    byte unsigned e[$], q[$];
    int g, s, c, k, mode;
    logic [31:0] w;
    for (int n = 0; n < 24; n++) begin
      k    = int'($urandom_range(0, 2));
      mode = int'($urandom_range(0, 2));
      w    = $urandom >> (4 * $urandom_range(0, 8));
      model(k, w, e);
      accept(k, w, 1'b0);
      collect(k, mode, e.size(), 1'b0, q, g, s, c);
      checks++;
      if (to_hex(q) != to_hex(e) || g != 0 || s != 0 || c != 0) begin
        errors++;
        $display("FAIL rand_word k=%0d w=%h got %s gaps=%0d chg=%0d ctl=%0d required %s 0 0 0",
                 k, w, to_hex(q), g, s, c, to_hex(e));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b0;
      idat[k] = 32'h0;
    end
    test_reset();
    test_deadbeef();
    test_backpressure();
    test_lowercase();
    test_back_to_back();
    test_reset_midstream();
    test_leadzero_edges();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
